// File: rtl/bsg_locking_arb_pkt_mux.sv
// Packet-granular mux behind a locking arbiter: routes a header and its body
// beats from one channel to a single output, releasing the lock on the last beat.

module bsg_locking_arb_pkt_mux_lane #(
   parameter int idx_p   = 0,
   parameter int sel_w_p = 1
) (
   input  logic [sel_w_p-1:0] i_sel,
   input  logic [sel_w_p-1:0] i_owner,
   input  logic               i_hs,
   input  logic               i_grant,
   output logic               o_yumi,
   output logic               o_mismatch
);
   assign o_yumi     = (i_sel == sel_w_p'(idx_p)) & i_hs;
   // Grant bit must agree with one-hot(owner) while a packet is locked.
   assign o_mismatch = i_grant ^ (i_owner == sel_w_p'(idx_p));
endmodule

module bsg_locking_arb_pkt_mux #(
   parameter int els_p       = 4,
   parameter int width_p     = 16,
   parameter int len_width_p = 4,
   localparam int sel_w_lp   = (els_p > 1) ? $clog2(els_p) : 1
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [els_p-1:0]         grants_i,
   input  logic [els_p-1:0]         v_i,
   input  logic [els_p*width_p-1:0] data_i,
   output logic [els_p-1:0]         yumi_o,
   output logic                     v_o,
   output logic [width_p-1:0]       data_o,
   input  logic                     ready_i,
   output logic                     unlock_o,
   output logic [sel_w_lp-1:0]      owner_o,
   output logic                     err_o
);

   typedef enum logic {S_IDLE, S_BODY} state_e;

   state_e                 r_state, w_state_nxt;
   logic [len_width_p-1:0] r_count, w_count_nxt;
   logic [sel_w_lp-1:0]    r_owner, w_owner_nxt;
   logic                   r_err,   w_err_nxt;

   logic [sel_w_lp-1:0]    w_idle_sel, w_sel;
   logic                   w_any_grant, w_multi_grant, w_body_err;
   logic                   w_hs, w_last;
   logic [els_p-1:0]       w_mismatch;
   logic [width_p-1:0]     w_beat;
   logic [len_width_p-1:0] w_len;

   always_comb begin
      w_idle_sel = '0;
      for (int i = els_p-1; i >= 0; i--)
         if (grants_i[i]) w_idle_sel = sel_w_lp'(i);
   end

   assign w_any_grant   = |grants_i;
   assign w_multi_grant = |(grants_i & (grants_i - els_p'(1)));
   // Once locked, routing follows the owner and ignores the grant vector.
   assign w_sel  = (r_state == S_BODY) ? r_owner : w_idle_sel;
   assign w_beat = data_i[w_sel*width_p +: width_p];
   assign w_len  = w_beat[len_width_p-1:0];

   assign v_o    = ~reset_i & ((r_state == S_BODY) ? v_i[r_owner]
                                                   : (w_any_grant & v_i[w_idle_sel]));
   assign data_o = (reset_i | ((r_state == S_IDLE) & ~w_any_grant)) ? '0 : w_beat;
   assign w_hs   = v_o & ready_i;

   assign w_last   = w_hs & ((r_state == S_IDLE) ? (w_len == '0)
                                                 : (r_count == len_width_p'(1)));
   assign unlock_o = reset_i | w_last;
   assign owner_o  = w_sel;
   assign err_o    = r_err;

   for (genvar g = 0; g < els_p; g++) begin : g_lane
      bsg_locking_arb_pkt_mux_lane #(.idx_p(g), .sel_w_p(sel_w_lp)) u_lane (
         .i_sel      (w_sel),
         .i_owner    (r_owner),
         .i_hs       (w_hs),
         .i_grant    (grants_i[g]),
         .o_yumi     (yumi_o[g]),
         .o_mismatch (w_mismatch[g])
      );
   end

   assign w_body_err = w_any_grant & (|w_mismatch);

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_owner_nxt = r_owner;
      w_err_nxt   = r_err | ((r_state == S_IDLE) ? w_multi_grant : w_body_err);
      case (r_state)
         S_IDLE: begin
            if (w_hs) begin
               w_owner_nxt = w_idle_sel;
               if (w_len != '0) begin
                  w_count_nxt = w_len;
                  w_state_nxt = S_BODY;
               end
            end
         end
         S_BODY: begin
            if (w_hs) begin
               w_count_nxt = r_count - len_width_p'(1);
               if (r_count == len_width_p'(1)) w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_owner <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_owner <= w_owner_nxt;
         r_err   <= w_err_nxt;
      end
   end

endmodule

// File: tb/tb_bsg_locking_arb_pkt_mux.sv
// Directed bench: stimulus pushes hand-computed expected handshakes into a
// queue; a monitor pops and compares each handshake the mux presents.

module tb_bsg_locking_arb_pkt_mux;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic [3:0]  grants_i = '0;
   logic [3:0]  v_i = '0;
   logic [63:0] data_i = '0;
   logic [3:0]  yumi_o;
   logic        v_o;
   logic [15:0] data_o;
   logic        ready_i = 1'b0;
   logic        unlock_o;
   logic [1:0]  owner_o;
   logic        err_o;

   typedef struct packed {
      logic [15:0] d;
      logic [3:0]  y;
      logic        u;
      logic [1:0]  o;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   bsg_locking_arb_pkt_mux #(.els_p(4), .width_p(16), .len_width_p(4)) dut (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .grants_i (grants_i),
      .v_i      (v_i),
      .data_i   (data_i),
      .yumi_o   (yumi_o),
      .v_o      (v_o),
      .data_o   (data_o),
      .ready_i  (ready_i),
      .unlock_o (unlock_o),
      .owner_o  (owner_o),
      .err_o    (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge, then settle to the
   // falling edge where all checks sample.
   task automatic step(input logic rst, input logic [3:0] g, input logic [3:0] v,
                       input logic rdy, input int ch, input logic [15:0] d,
                       input bit hs, input logic [3:0] ey, input logic eu,
                       input logic [1:0] eo);
      exp_t e;
      @(posedge clk_i); #1;
      reset_i  = rst;
      grants_i = g;
      v_i      = v;
      ready_i  = rdy;
      for (int i = 0; i < 4; i++) data_i[i*16 +: 16] = 16'hC0D0 + 16'(i);
      data_i[ch*16 +: 16] = d;
      if (hs) begin
         e.d = d; e.y = ey; e.u = eu; e.o = eo;
         exp_q.push_back(e);
      end
      @(negedge clk_i);
   endtask

   always @(negedge clk_i) begin
      exp_t e;
      if (reset_i === 1'b0) begin
         if (v_o && ready_i) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_handshake", {16'h0, data_o}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("hs_data",   32'(data_o),   32'(e.d));
               chk("hs_yumi",   32'(yumi_o),   32'(e.y));
               chk("hs_unlock", 32'(unlock_o), 32'(e.u));
               chk("hs_owner",  32'(owner_o),  32'(e.o));
            end
         end else begin
            chk("idle_yumi",   32'(yumi_o),   32'h0);
            chk("idle_unlock", 32'(unlock_o), 32'h0);
         end
      end
   end

   initial begin
      // reset with live inputs: outputs held quiet, lock released
      step(1, 4'b0100, 4'b1111, 1, 2, 16'h0003, 0, '0, 0, 0);
      step(1, 4'b0100, 4'b1111, 1, 2, 16'h0003, 0, '0, 0, 0);
      chk("rst_v",      32'(v_o),      32'h0);
      chk("rst_yumi",   32'(yumi_o),   32'h0);
      chk("rst_unlock", 32'(unlock_o), 32'h1);
      chk("rst_data",   32'(data_o),   32'h0);
      chk("rst_err",    32'(err_o),    32'h0);

      // IDLE with no grant: nothing presented
      step(0, 4'b0000, 4'b1111, 1, 0, 16'h1234, 0, '0, 0, 0);
      chk("nogrant_v",    32'(v_o),    32'h0);
      chk("nogrant_data", 32'(data_o), 32'h0);

      // ch2 header len 3 plus three body beats; unlock on the 4th handshake
      step(0, 4'b0100, 4'b0100, 1, 2, 16'h0003, 1, 4'b0100, 0, 2);
      step(0, 4'b0100, 4'b0100, 1, 2, 16'h1111, 1, 4'b0100, 0, 2);
      step(0, 4'b0100, 4'b0100, 1, 2, 16'h2222, 1, 4'b0100, 0, 2);
      step(0, 4'b0100, 4'b0100, 1, 2, 16'h3333, 1, 4'b0100, 1, 2);

      // back-to-back: zero-length header from ch0 right after the last beat
      step(0, 4'b0001, 4'b0001, 1, 0, 16'h0050, 1, 4'b0001, 1, 0);

      // ch1 len 2 with downstream stalls in the body
      step(0, 4'b0010, 4'b0010, 1, 1, 16'h0002, 1, 4'b0010, 0, 1);
      step(0, 4'b0010, 4'b0010, 1, 1, 16'hAAA1, 1, 4'b0010, 0, 1);
      step(0, 4'b0010, 4'b0010, 0, 1, 16'hAAA9, 0, '0, 0, 0);
      chk("stall_v_hi",  32'(v_o),     32'h1);
      chk("stall_owner", 32'(owner_o), 32'h1);
      step(0, 4'b0010, 4'b0000, 0, 1, 16'hAAA9, 0, '0, 0, 0);
      chk("stall_v_lo",  32'(v_o),     32'h0);
      step(0, 4'b0010, 4'b0010, 1, 1, 16'hAAA2, 1, 4'b0010, 1, 1);
      chk("err_clean",   32'(err_o),   32'h0);

      // grant moves to ch3 mid-packet: routing stays on ch1, error sticks
      step(0, 4'b0010, 4'b0010, 1, 1, 16'h0012, 1, 4'b0010, 0, 1);
      step(0, 4'b1000, 4'b1010, 1, 1, 16'hB001, 1, 4'b0010, 0, 1);
      step(0, 4'b0010, 4'b0010, 1, 1, 16'hB002, 1, 4'b0010, 1, 1);
      chk("err_body_set", 32'(err_o), 32'h1);
      step(0, 4'b0000, 4'b0000, 0, 0, 16'h0000, 0, '0, 0, 0);
      chk("err_sticky",   32'(err_o), 32'h1);

      // reset while ch3 holds a len-5 packet
      step(0, 4'b1000, 4'b1000, 1, 3, 16'h0005, 1, 4'b1000, 0, 3);
      step(1, 4'b1000, 4'b1111, 1, 3, 16'h7777, 0, '0, 0, 0);
      chk("midrst_v",      32'(v_o),      32'h0);
      chk("midrst_yumi",   32'(yumi_o),   32'h0);
      chk("midrst_unlock", 32'(unlock_o), 32'h1);
      step(0, 4'b0001, 4'b0001, 0, 0, 16'h4444, 0, '0, 0, 0);
      chk("postrst_err",   32'(err_o),   32'h0);
      chk("postrst_owner", 32'(owner_o), 32'h0);
      chk("postrst_v",     32'(v_o),     32'h1);
      chk("postrst_data",  32'(data_o),  32'h4444);
      step(0, 4'b0001, 4'b0001, 1, 0, 16'h4440, 1, 4'b0001, 1, 0);

      // two grants in IDLE: lowest index routes, error flagged
      step(0, 4'b0110, 4'b0110, 1, 1, 16'h0000, 1, 4'b0010, 1, 1);
      step(0, 4'b0000, 4'b0000, 0, 0, 16'h0000, 0, '0, 0, 0);
      chk("err_multi", 32'(err_o), 32'h1);

      @(posedge clk_i); #1;
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
